// File: rtl/exe_arb_pkg.sv
// exe_arb_pkg: shared types and constants for the execution-unit arbiter.
//   arb_state_t : sequencer states IDLE / EXEC / RESP
//   STATUS_W    : execution unit status width
//   NREQ        : number of requesters
//   LAT_DEFAULT : default execution unit latency (clock edges)
package exe_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int STATUS_W    = 4;
    localparam int NREQ        = 2;
    localparam int LAT_DEFAULT = 1;
endpackage

// File: rtl/exe_unit_arb_if.sv
// exe_unit_arb_if: bundles the client request/response handshakes, the
// execution unit command/result bus and the busy flag of exe_unit_arb.
//   slave  : arbiter view (drives o_*, samples i_*)
//   master : client + execution unit view (drives i_*, samples o_*)
// Params: m = operand/result width, n = opcode width.
interface exe_unit_arb_if import exe_arb_pkg::*; #(
    parameter int m = 4,
    parameter int n = 2
);
    logic [NREQ-1:0]     i_req_valid;
    logic [NREQ-1:0]     o_req_ready;
    logic [n-1:0]        i_req_oper0, i_req_oper1;
    logic [m-1:0]        i_req_argA0, i_req_argA1;
    logic [m-1:0]        i_req_argB0, i_req_argB1;
    logic [NREQ-1:0]     o_rsp_valid;
    logic [NREQ-1:0]     i_rsp_ready;
    logic [m-1:0]        o_rsp_result;
    logic [STATUS_W-1:0] o_rsp_status;
    logic [n-1:0]        o_exe_oper;
    logic [m-1:0]        o_exe_argA, o_exe_argB;
    logic [m-1:0]        i_exe_result;
    logic [STATUS_W-1:0] i_exe_status;
    logic                o_busy;

    modport slave (
        input  i_req_valid, i_req_oper0, i_req_oper1,
               i_req_argA0, i_req_argA1, i_req_argB0, i_req_argB1,
               i_rsp_ready, i_exe_result, i_exe_status,
        output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_status,
               o_exe_oper, o_exe_argA, o_exe_argB, o_busy
    );

    modport master (
        output i_req_valid, i_req_oper0, i_req_oper1,
               i_req_argA0, i_req_argA1, i_req_argB0, i_req_argB1,
               i_rsp_ready, i_exe_result, i_exe_status,
        input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_status,
               o_exe_oper, o_exe_argA, o_exe_argB, o_busy
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way grant.
//   valid[1:0] : requests
//   ptr        : preferred requester on a tie (only with EXE_ARB_RR_EN)
//   grant[1:0] : one-hot grant, zero when nothing is valid
// Macro EXE_ARB_RR_EN: round-robin tie break via ptr; otherwise requester 0
// wins every tie and the ptr port does not exist.
module rr_arb2 (
    input  logic [1:0] valid,
`ifdef EXE_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] grant
);
    always_comb begin
        grant = valid;
`ifdef EXE_ARB_RR_EN
        if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
`else
        if (valid[0]) grant = 2'b01;
`endif
    end
endmodule

// File: rtl/exe_unit_arb.sv
// exe_unit_arb: arbitrates two clients onto one shared execution unit.
// A granted command is held on o_exe_* for LAT+1 cycles; the unit output is
// captured on the last of them and returned to the granted client, which
// holds the sequencer in RESP until it consumes the response.
//   i_clk, i_rsn : clock (rising), async active-low reset
//   bus (slave)  : request/response handshakes, execution unit bus, o_busy
// Macro EXE_ARB_RR_EN: round-robin tie break (default build: requester 0
// has fixed priority).
module exe_unit_arb import exe_arb_pkg::*; #(
    parameter int m   = 4,
    parameter int n   = 2,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rsn,
    exe_unit_arb_if.slave bus
);
    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    arb_state_t          state_q, state_d;
    logic                g_q, g_d;          // granted requester index
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [n-1:0]        oper_q, oper_d;
    logic [m-1:0]        arga_q, arga_d, argb_q, argb_d;
    logic [m-1:0]        res_q, res_d;
    logic [STATUS_W-1:0] st_q, st_d;
    logic [NREQ-1:0]     gnt;

`ifdef EXE_ARB_RR_EN
    logic ptr_q, ptr_d;
    rr_arb2 u_arb (.valid(bus.i_req_valid), .ptr(ptr_q), .grant(gnt));
`else
    rr_arb2 u_arb (.valid(bus.i_req_valid), .grant(gnt));
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        oper_d  = oper_q;
        arga_d  = arga_q;
        argb_d  = argb_q;
        res_d   = res_q;
        st_d    = st_q;
`ifdef EXE_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: if (|bus.i_req_valid) begin
                g_d     = gnt[1];
                oper_d  = gnt[1] ? bus.i_req_oper1 : bus.i_req_oper0;
                arga_d  = gnt[1] ? bus.i_req_argA1 : bus.i_req_argA0;
                argb_d  = gnt[1] ? bus.i_req_argB1 : bus.i_req_argB0;
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                // The unit registers the command LAT times; sample on the
                // cycle after the last of those edges.
                if (cnt_q == CNT_W'(LAT)) begin
                    res_d   = bus.i_exe_result;
                    st_d    = bus.i_exe_status;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: if (bus.i_rsp_ready[g_q]) begin
                state_d = IDLE;
`ifdef EXE_ARB_RR_EN
                ptr_d   = ~g_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            cnt_q   <= '0;
            oper_q  <= '0;
            arga_q  <= '0;
            argb_q  <= '0;
            res_q   <= '0;
            st_q    <= '0;
`ifdef EXE_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            oper_q  <= oper_d;
            arga_q  <= arga_d;
            argb_q  <= argb_d;
            res_q   <= res_d;
            st_q    <= st_d;
`ifdef EXE_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.o_req_ready  = (state_q == IDLE) ? gnt : '0;
    assign bus.o_rsp_valid  = (state_q == RESP) ? {g_q, ~g_q} : '0;
    assign bus.o_rsp_result = res_q;
    assign bus.o_rsp_status = st_q;
    assign bus.o_exe_oper   = oper_q;
    assign bus.o_exe_argA   = arga_q;
    assign bus.o_exe_argB   = argb_q;
    assign bus.o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_exe_unit_arb.sv
// tb_exe_unit_arb: directed scenarios followed by random traffic, checked
// every cycle against a transaction-level model: an outstanding command is
// answered LAT+2 cycles after acceptance with the execution unit function
// of its operands, and held until the granted client consumes it.
module tb_exe_unit_arb;
    import exe_arb_pkg::*;

    localparam int M = 4;
    localparam int N = 2;
    localparam int L = LAT_DEFAULT;
    localparam int RW = M + STATUS_W;

    logic i_clk = 1'b0;
    logic i_rsn = 1'b1;
    always #5 i_clk = ~i_clk;

    exe_unit_arb_if #(.m(M), .n(N)) bus();
    exe_unit_arb #(.m(M), .n(N), .LAT(L)) dut (.i_clk(i_clk), .i_rsn(i_rsn), .bus(bus));

    // Stand-in execution unit: {status, result}, status = {carry, zero, oper}
    function automatic logic [RW-1:0] exe_fn(input logic [N-1:0] op,
                                             input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M:0] s;
        case (op)
            2'd0:    s = {1'b0, a} + {1'b0, b};
            2'd1:    s = {1'b0, a} - {1'b0, b};
            2'd2:    s = {1'b0, a & b};
            default: s = {1'b0, a ^ b};
        endcase
        return {s[M], s[M-1:0] == '0, op, s[M-1:0]};
    endfunction

    logic [RW-1:0] exe_pipe [L];
    always @(posedge i_clk) begin
        exe_pipe[0] <= exe_fn(bus.o_exe_oper, bus.o_exe_argA, bus.o_exe_argB);
        for (int i = 1; i < L; i++) exe_pipe[i] <= exe_pipe[i-1];
    end
    assign bus.i_exe_result = exe_pipe[L-1][M-1:0];
    assign bus.i_exe_status = exe_pipe[L-1][RW-1:M];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Tie goes to the preferred requester; the pointer never moves in the
    // fixed-priority build, so preferring 0 is fixed priority.
    function automatic logic [1:0] pick(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Reference model state
    logic          busy_m = 1'b0, g_m = 1'b0, ptr_m = 1'b0;
    int            cyc_m = 0;
    logic [N-1:0]  op_m = '0;
    logic [M-1:0]  a_m = '0, b_m = '0;
    logic [RW-1:0] exp_m = '0;
    logic [1:0]    exp_rdy, exp_rv;

    always @(negedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            #1;
            chk("rst_req_ready", bus.o_req_ready, 0);
            chk("rst_rsp_valid", bus.o_rsp_valid, 0);
            chk("rst_result",    bus.o_rsp_result, 0);
            chk("rst_status",    bus.o_rsp_status, 0);
            chk("rst_exe_cmd",   {bus.o_exe_oper, bus.o_exe_argA, bus.o_exe_argB}, 0);
            chk("rst_busy",      bus.o_busy, 0);
            busy_m = 1'b0; ptr_m = 1'b0; cyc_m = 0;
            op_m = '0; a_m = '0; b_m = '0;
        end else begin
            exp_rdy = busy_m ? 2'b00 : pick(bus.i_req_valid, ptr_m);
            exp_rv  = (busy_m && cyc_m >= L + 2) ? (g_m ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", bus.o_req_ready, exp_rdy);
            chk("rsp_valid", bus.o_rsp_valid, exp_rv);
            chk("busy",      bus.o_busy, busy_m);
            chk("exe_cmd",   {bus.o_exe_oper, bus.o_exe_argA, bus.o_exe_argB}, {op_m, a_m, b_m});
            if (exp_rv != 2'b00) begin
                chk("rsp_result", bus.o_rsp_result, exp_m[M-1:0]);
                chk("rsp_status", bus.o_rsp_status, exp_m[RW-1:M]);
            end
            if (busy_m) begin
                if (exp_rv != 2'b00 && bus.i_rsp_ready[g_m]) begin
                    busy_m = 1'b0;
`ifdef EXE_ARB_RR_EN
                    ptr_m = ~g_m;
`endif
                end else begin
                    cyc_m++;
                end
            end else if (exp_rdy != 2'b00) begin
                g_m    = exp_rdy[1];
                op_m   = g_m ? bus.i_req_oper1 : bus.i_req_oper0;
                a_m    = g_m ? bus.i_req_argA1 : bus.i_req_argA0;
                b_m    = g_m ? bus.i_req_argB1 : bus.i_req_argB0;
                exp_m  = exe_fn(op_m, a_m, b_m);
                busy_m = 1'b1;
                cyc_m  = 1;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [N-1:0] op,
                           input logic [M-1:0] a, input logic [M-1:0] b);
        if (k == 0) begin
            bus.i_req_oper0 = op; bus.i_req_argA0 = a; bus.i_req_argB0 = b;
        end else begin
            bus.i_req_oper1 = op; bus.i_req_argA1 = a; bus.i_req_argB1 = b;
        end
    endtask

    initial begin
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b00;
        set_req(0, 2'd0, 4'd0, 4'd0);
        set_req(1, 2'd0, 4'd0, 4'd0);
        #1 i_rsn = 1'b0;
        repeat (2) @(posedge i_clk);
        #2 i_rsn = 1'b1;

        // Single request from requester 0: 3 + 5
        tick(1);
        set_req(0, 2'd0, 4'd3, 4'd5);
        bus.i_req_valid = 2'b01;
        bus.i_rsp_ready = 2'b01;
        tick(1);
        bus.i_req_valid = 2'b00;
        tick(L + 4);

        // Both clients valid continuously, consuming immediately
        set_req(0, 2'd1, 4'd2, 4'd7);
        set_req(1, 2'd3, 4'd9, 4'd6);
        bus.i_req_valid = 2'b11;
        bus.i_rsp_ready = 2'b11;
        tick(4 * (L + 3));
        bus.i_req_valid = 2'b00;
        tick(L + 4);

        // Response stall, with requester 1 pulsing valid during RESP
        bus.i_rsp_ready = 2'b00;
        set_req(0, 2'd2, 4'hC, 4'hA);
        bus.i_req_valid = 2'b01;
        tick(1);
        bus.i_req_valid = 2'b00;
        tick(L + 2);
        bus.i_req_valid = 2'b10;
        bus.i_rsp_ready = 2'b10;
        tick(2);
        bus.i_req_valid = 2'b00;
        tick(3);
        bus.i_rsp_ready = 2'b01;
        tick(2);

        // Reset pulse in the first EXEC cycle, then a tie after reset
        set_req(1, 2'd0, 4'hF, 4'h1);
        bus.i_req_valid = 2'b10;
        tick(1);
        bus.i_req_valid = 2'b00;
        #1 i_rsn = 1'b0;
        #2 i_rsn = 1'b1;
        tick(L + 4);
        set_req(0, 2'd1, 4'h1, 4'h4);
        bus.i_req_valid = 2'b11;
        tick(1);
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b11;
        tick(L + 4);

        // Random traffic: valids may drop before acceptance, stalls random
        for (int c = 0; c < 3000; c++) begin
            bus.i_req_valid = 2'($urandom);
            set_req(0, N'($urandom), M'($urandom), M'($urandom));
            set_req(1, N'($urandom), M'($urandom), M'($urandom));
            bus.i_rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
            tick(1);
        end
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b11;
        tick(L + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
